// File: rtl/alarm_ringer_if.sv
// Control and status bundle between the alarm comparator side and alarm_ringer.
interface alarm_ringer_if;
    logic       tick_1hz;
    logic       alert;
    logic       en;
    logic       btn_stop;
    logic       btn_snooze;
    logic       ringing;
    logic       snoozing;
    logic       buzzer;
    logic       missed;
    logic [3:0] snooze_used;

    modport master (
        output tick_1hz, alert, en, btn_stop, btn_snooze,
        input  ringing, snoozing, buzzer, missed, snooze_used
    );

    modport slave (
        input  tick_1hz, alert, en, btn_stop, btn_snooze,
        output ringing, snoozing, buzzer, missed, snooze_used
    );
endinterface

// File: rtl/alarm_ringer.sv
// alarm_ringer: alert-edge triggered ring / snooze sequencer paced by the 1 Hz tick.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and the snooze counter.
module alarm_ringer #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input logic           clk,
    input logic           rst_n,
    alarm_ringer_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for an alert rise while enabled
    // RING   | buzzer gated 1 s on / 1 s off, ring timer running
    // SNOOZE | buzzer silent, snooze timer running

    localparam int MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CW      = $clog2(MAX_SEC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] sec_cnt, sec_cnt_d;
    logic          alert_q;
    logic          ringing_q, buzzer_q, missed_q;
    logic          ringing_d, buzzer_d, missed_d;
    logic          alert_rise, tick_eff, ring_done, timeout;

    assign alert_rise = bus.alert & ~alert_q;
    assign ring_done  = tick_eff && (sec_cnt == CW'(RING_SEC - 1));

`ifdef ALARM_SNOOZE_EN
    logic [3:0] used_q;
    logic       snoozing_q;
    logic       snooze_ok, snooze_done;

    // any button in the same cycle swallows the tick, even one that is ignored
    assign tick_eff    = bus.tick_1hz & ~bus.btn_stop & ~bus.btn_snooze;
    assign snooze_ok   = bus.btn_snooze && (used_q < 4'(MAX_SNOOZE));
    assign snooze_done = tick_eff && (sec_cnt == CW'(SNOOZE_SEC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q     <= '0;
            snoozing_q <= 1'b0;
        end else begin
            snoozing_q <= (state_d == SNOOZE);
            if (state == IDLE && state_d == RING)
                used_q <= '0;
            else if (state == RING && state_d == SNOOZE)
                used_q <= used_q + 4'd1;
        end
    end

    assign bus.snoozing    = snoozing_q;
    assign bus.snooze_used = used_q;
`else
    assign tick_eff        = bus.tick_1hz & ~bus.btn_stop;
    assign bus.snoozing    = 1'b0;
    assign bus.snooze_used = 4'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sec_cnt   <= '0;
            alert_q   <= 1'b0;
            ringing_q <= 1'b0;
            buzzer_q  <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state     <= state_d;
            sec_cnt   <= sec_cnt_d;
            alert_q   <= bus.alert;
            ringing_q <= ringing_d;
            buzzer_q  <= buzzer_d;
            missed_q  <= missed_d;
        end
    end

    always_comb begin
        state_d = state;
        timeout = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (alert_rise)
                        state_d = RING;
                end
                RING: begin
                    if (bus.btn_stop)
                        state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
                    else if (snooze_ok)
                        state_d = SNOOZE;
`endif
                    else if (ring_done) begin
                        state_d = IDLE;
                        timeout = 1'b1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (bus.btn_stop)
                        state_d = IDLE;
                    else if (snooze_done)
                        state_d = RING;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ringing_d = (state_d == RING);
        missed_d  = timeout;
        buzzer_d  = 1'b0;
        sec_cnt_d = sec_cnt;
        if (state_d != state)
            sec_cnt_d = '0;
        else if (state != IDLE && tick_eff)
            sec_cnt_d = sec_cnt + 1'b1;
        if (state_d == RING) begin
            if (state != RING)
                buzzer_d = 1'b1;
            else if (tick_eff)
                buzzer_d = ~buzzer_q;
            else
                buzzer_d = buzzer_q;
        end
    end

    assign bus.ringing = ringing_q;
    assign bus.buzzer  = buzzer_q;
    assign bus.missed  = missed_q;
endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with a seconds-remaining reference model.
module tb_alarm_ringer;
    localparam int RING_T = 4;
    localparam int SNZ_T  = 3;
    localparam int MAXS   = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic clk, rst_n;
    logic tick, alert, en, btn_stop, btn_snooze;
    int   phase;
    int   checks, failures;

    alarm_ringer_if bus ();
    assign bus.tick_1hz   = tick;
    assign bus.alert      = alert;
    assign bus.en         = en;
    assign bus.btn_stop   = btn_stop;
    assign bus.btn_snooze = btn_snooze;

    alarm_ringer #(.RING_SEC(RING_T), .SNOOZE_SEC(SNZ_T), .MAX_SNOOZE(MAXS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference: ticks left in the current phase and ring ticks elapsed for the tone parity
    typedef struct {
        bit ringing;
        bit snoozing;
        bit buzzer;
        bit missed;
        int used;
        int left;
        int rticks;
        bit alert_prev;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t mstep(mstate_t c, bit a, bit e, bit stp, bit snz, bit tk);
        mstate_t n = c;
        bit rise   = a && !c.alert_prev;
        bit snz_on = SNZ_EN && snz;
        n.alert_prev = a;
        n.missed     = 1'b0;
        if (!e) begin
            n.ringing  = 1'b0;
            n.snoozing = 1'b0;
        end else if (!c.ringing && !c.snoozing) begin
            if (rise) begin
                n.ringing = 1'b1;
                n.left    = RING_T;
                n.rticks  = 0;
                n.used    = 0;
            end
        end else if (stp) begin
            n.ringing  = 1'b0;
            n.snoozing = 1'b0;
        end else if (c.ringing && snz_on && c.used < MAXS) begin
            n.ringing  = 1'b0;
            n.snoozing = 1'b1;
            n.left     = SNZ_T;
            n.used     = c.used + 1;
        end else if (tk && !snz_on) begin
            n.left = c.left - 1;
            if (c.ringing) n.rticks = c.rticks + 1;
            if (n.left == 0) begin
                if (c.ringing) begin
                    n.ringing = 1'b0;
                    n.missed  = 1'b1;
                end else begin
                    n.snoozing = 1'b0;
                    n.ringing  = 1'b1;
                    n.left     = RING_T;
                    n.rticks   = 0;
                end
            end
        end
        n.buzzer = n.ringing && (n.rticks % 2 == 0);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= mstep(m, alert, en, btn_stop, btn_snooze, tick);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_ringing",  int'(bus.ringing),     int'(m.ringing));
        check("model_snoozing", int'(bus.snoozing),    int'(m.snoozing));
        check("model_buzzer",   int'(bus.buzzer),      int'(m.buzzer));
        check("model_missed",   int'(bus.missed),      int'(m.missed));
        check("model_used",     int'(bus.snooze_used), SNZ_EN ? m.used : 0);
    end

    // one clock; afterwards pulses are cleared and tick is set for the coming edge
    task automatic step();
        @(posedge clk);
        #2;
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;
        phase      = (phase == 9) ? 0 : phase + 1;
        tick       = (phase == 9);
    endtask

    task automatic to_tick();
        while (!tick) step();
    endtask

    task automatic fire();
        alert = 1'b0;
        step();
        alert = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0; phase = 0;
        rst_n = 1'b0; tick = 1'b0; alert = 1'b0; en = 1'b0;
        btn_stop = 1'b0; btn_snooze = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_ringing", int'(bus.ringing), 0);
        check("reset_buzzer",  int'(bus.buzzer), 0);
        check("reset_used",    int'(bus.snooze_used), 0);
        rst_n = 1'b1;
        step(); step();
        en = 1'b1;
        step();

        // basic ring, tone toggle, stop, no re-fire while alert stays high
        to_tick(); step();
        alert = 1'b1;
        step();
        check("ring_start_ringing", int'(bus.ringing), 1);
        check("ring_start_buzzer",  int'(bus.buzzer), 1);
        to_tick(); step();
        check("buzzer_tick1", int'(bus.buzzer), 0);
        to_tick(); step();
        check("buzzer_tick2", int'(bus.buzzer), 1);
        btn_stop = 1'b1;
        step();
        check("stop_ringing", int'(bus.ringing), 0);
        repeat (20) begin to_tick(); step(); end
        check("no_refire", int'(bus.ringing), 0);
        alert = 1'b0;
        step();

        // timeout after RING_T ticks
        fire();
        check("to_start", int'(bus.ringing), 1);
        repeat (RING_T - 1) begin to_tick(); step(); end
        check("to_before_ringing", int'(bus.ringing), 1);
        check("to_before_missed",  int'(bus.missed), 0);
        to_tick(); step();
        check("to_missed",  int'(bus.missed), 1);
        check("to_ringing", int'(bus.ringing), 0);
        step();
        check("to_missed_one_cycle", int'(bus.missed), 0);

`ifdef ALARM_SNOOZE_EN
        // snooze cycle up to the limit
        fire();
        to_tick(); step();
        btn_snooze = 1'b1;
        step();
        check("snz1_snoozing", int'(bus.snoozing), 1);
        check("snz1_buzzer",   int'(bus.buzzer), 0);
        check("snz1_used",     int'(bus.snooze_used), 1);
        repeat (SNZ_T - 1) begin to_tick(); step(); end
        check("snz1_still", int'(bus.snoozing), 1);
        to_tick(); step();
        check("rering_ringing", int'(bus.ringing), 1);
        check("rering_buzzer",  int'(bus.buzzer), 1);
        btn_snooze = 1'b1;
        step();
        check("snz2_used", int'(bus.snooze_used), 2);
        repeat (SNZ_T) begin to_tick(); step(); end
        check("rering2_ringing", int'(bus.ringing), 1);
        btn_snooze = 1'b1;
        step();
        check("snz3_ignored_ringing", int'(bus.ringing), 1);
        check("snz3_ignored_used",    int'(bus.snooze_used), 2);

        // ignored snooze coincident with a tick: that tick is lost
        to_tick();
        btn_snooze = 1'b1;
        step();
        repeat (RING_T - 1) begin to_tick(); step(); end
        check("late_to_ringing", int'(bus.ringing), 1);
        to_tick(); step();
        check("late_to_missed", int'(bus.missed), 1);

        // stop beats snooze
        fire();
        btn_snooze = 1'b1;
        step();
        repeat (SNZ_T) begin to_tick(); step(); end
        btn_stop = 1'b1; btn_snooze = 1'b1;
        step();
        check("both_ringing",  int'(bus.ringing), 0);
        check("both_snoozing", int'(bus.snoozing), 0);
        check("both_used",     int'(bus.snooze_used), 1);
`else
        // snooze absent: button does nothing and ring still times out
        fire();
        to_tick(); step();
        btn_snooze = 1'b1;
        step();
        check("nosnz_ringing",  int'(bus.ringing), 1);
        check("nosnz_snoozing", int'(bus.snoozing), 0);
        repeat (RING_T - 2) begin to_tick(); step(); end
        check("nosnz_before", int'(bus.ringing), 1);
        to_tick(); step();
        check("nosnz_missed", int'(bus.missed), 1);
`endif

        // enable drop mid ring
        fire();
        step();
        en = 1'b0;
        step();
        check("endrop_ringing", int'(bus.ringing), 0);
        check("endrop_buzzer",  int'(bus.buzzer), 0);
        en = 1'b1;
        step();

        // async reset mid snooze (mid ring without snooze)
        fire();
        btn_snooze = 1'b1;
        step();
        check("prereset_active", int'(bus.ringing | bus.snoozing), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_ringing",  int'(bus.ringing), 0);
        check("async_snoozing", int'(bus.snoozing), 0);
        check("async_buzzer",   int'(bus.buzzer), 0);
        check("async_used",     int'(bus.snooze_used), 0);
        alert = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step();
        en = 1'b1;
        step();

        // rise while disabled never rings, even after enabling
        en = 1'b0;
        step();
        alert = 1'b1;
        step();
        check("dis_rise", int'(bus.ringing), 0);
        en = 1'b1;
        repeat (3) step();
        check("dis_rise_late", int'(bus.ringing), 0);
        alert = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
